// File: rtl/csr_access_unit_if.sv
// Bundle of request, CSR-file and response signals for csr_access_unit.
// The unit connects as slave; the surrounding pipeline/CSR file connects as master.
interface csr_access_unit_if #(
    parameter int CSR_AW = 32,
    parameter int XLEN   = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [11:0]       req_csr;
    logic [XLEN-1:0]   req_rs1_data;
    logic [4:0]        req_rs1_idx;
    logic [4:0]        req_rd_idx;

    logic [CSR_AW-1:0] csr_raddr;
    logic [XLEN-1:0]   csr_rdata;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              csr_we;

    logic              resp_valid;
    logic              resp_ready;
    logic [4:0]        resp_rd_idx;
    logic [XLEN-1:0]   resp_rd_data;
    logic              resp_rd_we;
    logic              resp_illegal;

    modport master (
        output req_valid, req_funct3, req_csr, req_rs1_data, req_rs1_idx, req_rd_idx,
        input  req_ready,
        input  csr_raddr, csr_waddr, csr_wdata, csr_we,
        output csr_rdata,
        input  resp_valid, resp_rd_idx, resp_rd_data, resp_rd_we, resp_illegal,
        output resp_ready
    );

    modport slave (
        input  req_valid, req_funct3, req_csr, req_rs1_data, req_rs1_idx, req_rd_idx,
        output req_ready,
        output csr_raddr, csr_waddr, csr_wdata, csr_we,
        input  csr_rdata,
        output resp_valid, resp_rd_idx, resp_rd_data, resp_rd_we, resp_illegal,
        input  resp_ready
    );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr execute-stage initiator: sequences CSR read, read-modify-write and response.
// Optional macro CSR_ACCESS_UNIT_RO_CHECK_EN rejects writes to read-only CSR space (csr[11:10] == 2'b11).
module csr_access_unit #(
    parameter int CSR_AW = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    csr_access_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    // op encoding is funct3[1:0]: 01 write, 10 set, 11 clear, 00 illegal
    function automatic logic [XLEN-1:0] rmw_data(input logic [1:0] op,
                                                 input logic [XLEN-1:0] old_val,
                                                 input logic [XLEN-1:0] operand);
        case (op)
            2'b01:   rmw_data = operand;
            2'b10:   rmw_data = old_val | operand;
            2'b11:   rmw_data = old_val & ~operand;
            default: rmw_data = {XLEN{1'b0}};
        endcase
    endfunction

    function automatic logic [CSR_AW-1:0] zext_csr(input logic [11:0] csr);
        zext_csr = {{(CSR_AW-12){1'b0}}, csr};
    endfunction

    state_e            state_r, state_s;
    logic [1:0]        op_r, op_s;
    logic [11:0]       csr_r, csr_s;
    logic [XLEN-1:0]   operand_r, operand_s;
    logic [4:0]        rd_r, rd_s;
    logic              do_read_r, do_read_s;
    logic              do_write_r, do_write_s;
    logic              illegal_r, illegal_s;
    logic [XLEN-1:0]   old_r, old_s;

    logic              ready_r, ready_s;
    logic [CSR_AW-1:0] raddr_r, raddr_s;
    logic [CSR_AW-1:0] waddr_r, waddr_s;
    logic [XLEN-1:0]   wdata_r, wdata_s;
    logic              we_r, we_s;
    logic              resp_valid_r, resp_valid_s;
    logic [XLEN-1:0]   rd_data_r, rd_data_s;
    logic              rd_we_r, rd_we_s;
    logic              resp_illegal_r, resp_illegal_s;

    logic              accept_s;
    logic              in_is_rw_s;
    logic              in_illegal_s;
    logic              in_do_read_s;
    logic              in_do_write_s;

    // Decode of the incoming request, used only on accept
    always_comb begin
        in_is_rw_s    = (bus.req_funct3[1:0] == 2'b01);
        in_do_read_s  = !(in_is_rw_s && (bus.req_rd_idx == 5'd0));
        in_do_write_s = in_is_rw_s || (bus.req_rs1_idx != 5'd0);
`ifdef CSR_ACCESS_UNIT_RO_CHECK_EN
        in_illegal_s  = (bus.req_funct3[1:0] == 2'b00) ||
                        ((bus.req_csr[11:10] == 2'b11) && in_do_write_s);
`else
        in_illegal_s  = (bus.req_funct3[1:0] == 2'b00);
`endif
        accept_s      = bus.req_valid && ready_r;
    end

    // Next-state, captured operands and next registered outputs
    always_comb begin
        state_s    = state_r;
        op_s       = op_r;
        csr_s      = csr_r;
        operand_s  = operand_r;
        rd_s       = rd_r;
        do_read_s  = do_read_r;
        do_write_s = do_write_r;
        illegal_s  = illegal_r;
        old_s      = old_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    op_s       = bus.req_funct3[1:0];
                    csr_s      = bus.req_csr;
                    rd_s       = bus.req_rd_idx;
                    illegal_s  = in_illegal_s;
                    // illegal requests carry no read so the response data stays 0
                    do_read_s  = in_do_read_s && !in_illegal_s;
                    do_write_s = in_do_write_s && !in_illegal_s;
                    if (bus.req_funct3[2]) begin
                        operand_s = {{(XLEN-5){1'b0}}, bus.req_rs1_idx};
                    end else begin
                        operand_s = bus.req_rs1_data;
                    end
                    if (in_illegal_s) begin
                        state_s = RESP;
                    end else if (in_do_read_s) begin
                        state_s = READ;
                    end else if (in_do_write_s) begin
                        state_s = WRITE;
                    end else begin
                        state_s = RESP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                old_s = bus.csr_rdata;
                if (do_write_r) begin
                    state_s = WRITE;
                end else begin
                    state_s = RESP;
                end
            end
            WRITE: begin
                state_s = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        ready_s        = (state_s == IDLE);
        raddr_s        = (state_s == READ)  ? zext_csr(csr_s) : {CSR_AW{1'b0}};
        we_s           = (state_s == WRITE);
        waddr_s        = (state_s == WRITE) ? zext_csr(csr_s) : {CSR_AW{1'b0}};
        wdata_s        = (state_s == WRITE) ? rmw_data(op_s, old_s, operand_s) : {XLEN{1'b0}};
        resp_valid_s   = (state_s == RESP);
        rd_we_s        = (state_s == RESP) && do_read_s && !illegal_s && (rd_s != 5'd0);
        rd_data_s      = ((state_s == RESP) && do_read_s) ? old_s : {XLEN{1'b0}};
        resp_illegal_s = (state_s == RESP) && illegal_s;
    end

    // State, operand and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r        <= IDLE;
            op_r           <= 2'b00;
            csr_r          <= 12'd0;
            operand_r      <= {XLEN{1'b0}};
            rd_r           <= 5'd0;
            do_read_r      <= 1'b0;
            do_write_r     <= 1'b0;
            illegal_r      <= 1'b0;
            old_r          <= {XLEN{1'b0}};
            ready_r        <= 1'b1;
            raddr_r        <= {CSR_AW{1'b0}};
            waddr_r        <= {CSR_AW{1'b0}};
            wdata_r        <= {XLEN{1'b0}};
            we_r           <= 1'b0;
            resp_valid_r   <= 1'b0;
            rd_data_r      <= {XLEN{1'b0}};
            rd_we_r        <= 1'b0;
            resp_illegal_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            op_r           <= op_s;
            csr_r          <= csr_s;
            operand_r      <= operand_s;
            rd_r           <= rd_s;
            do_read_r      <= do_read_s;
            do_write_r     <= do_write_s;
            illegal_r      <= illegal_s;
            old_r          <= old_s;
            ready_r        <= ready_s;
            raddr_r        <= raddr_s;
            waddr_r        <= waddr_s;
            wdata_r        <= wdata_s;
            we_r           <= we_s;
            resp_valid_r   <= resp_valid_s;
            rd_data_r      <= rd_data_s;
            rd_we_r        <= rd_we_s;
            resp_illegal_r <= resp_illegal_s;
        end
    end

    assign bus.req_ready    = ready_r;
    assign bus.csr_raddr    = raddr_r;
    assign bus.csr_waddr    = waddr_r;
    assign bus.csr_wdata    = wdata_r;
    assign bus.csr_we       = we_r;
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_rd_idx  = rd_r;
    assign bus.resp_rd_data = rd_data_r;
    assign bus.resp_rd_we   = rd_we_r;
    assign bus.resp_illegal = resp_illegal_r;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed self-checking bench for csr_access_unit (latency, CSR traffic, response, backpressure, reset).
module tb_csr_access_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    csr_access_unit_if #(.CSR_AW(32), .XLEN(32)) bus ();

    csr_access_unit #(.CSR_AW(32), .XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [11:0] csr, input logic [31:0] rs1_data,
                             input logic [4:0] rs1_idx, input logic [4:0] rd);
        bus.req_valid    = 1'b1;
        bus.req_funct3   = f3;
        bus.req_csr      = csr;
        bus.req_rs1_data = rs1_data;
        bus.req_rs1_idx  = rs1_idx;
        bus.req_rd_idx   = rd;
    endtask

    // Issue one request, trace CSR traffic until the response appears, check everything.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [11:0] csr,
                          input logic [31:0] rs1_data, input logic [4:0] rs1_idx, input logic [4:0] rd,
                          input logic [31:0] csr_val, input int exp_reads, input int exp_writes,
                          input logic [31:0] exp_wdata, input int exp_lat, input logic exp_rd_we,
                          input logic [31:0] exp_rd_data, input logic exp_illegal, input logic handshake);
        int          cycles;
        int          reads;
        int          writes;
        logic [31:0] wdata_seen;
        logic        done;
        reads      = 0;
        writes     = 0;
        wdata_seen = 32'd0;
        done       = 1'b0;
        @(negedge clk);
        drive_req(f3, csr, rs1_data, rs1_idx, rd);
        bus.csr_rdata = csr_val;
        check_eq({name, ":ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        cycles = 1;
        while (!done && cycles <= 8) begin
            if (bus.csr_raddr != 32'd0) begin
                reads++;
                check_eq({name, ":raddr"}, bus.csr_raddr, {20'd0, csr});
            end
            if (bus.csr_we) begin
                writes++;
                wdata_seen = bus.csr_wdata;
                check_eq({name, ":waddr"}, bus.csr_waddr, {20'd0, csr});
            end
            if (bus.csr_raddr != 32'd0 && bus.csr_we) begin
                check_eq({name, ":rw_same_cycle"}, 32'd1, 32'd0);
            end
            if (bus.resp_valid) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cycles++;
            end
        end
        check_eq({name, ":resp_seen"}, {31'd0, done}, 32'd1);
        check_eq({name, ":latency"}, cycles, exp_lat);
        check_eq({name, ":reads"}, reads, exp_reads);
        check_eq({name, ":writes"}, writes, exp_writes);
        if (exp_writes > 0) begin
            check_eq({name, ":wdata"}, wdata_seen, exp_wdata);
        end
        check_eq({name, ":rd_idx"}, {27'd0, bus.resp_rd_idx}, {27'd0, rd});
        check_eq({name, ":rd_we"}, {31'd0, bus.resp_rd_we}, {31'd0, exp_rd_we});
        check_eq({name, ":rd_data"}, bus.resp_rd_data, exp_rd_data);
        check_eq({name, ":illegal"}, {31'd0, bus.resp_illegal}, {31'd0, exp_illegal});
        if (handshake) begin
            @(posedge clk);
            #1;
            check_eq({name, ":idle_ready"}, {31'd0, bus.req_ready}, 32'd1);
            check_eq({name, ":idle_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        end
    endtask

    initial begin
        int stray;
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_funct3   = 3'd0;
        bus.req_csr      = 12'd0;
        bus.req_rs1_data = 32'd0;
        bus.req_rs1_idx  = 5'd0;
        bus.req_rd_idx   = 5'd0;
        bus.csr_rdata    = 32'd0;
        bus.resp_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset:ready", {31'd0, bus.req_ready}, 32'd1);
        check_eq("reset:resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("reset:we", {31'd0, bus.csr_we}, 32'd0);
        check_eq("reset:raddr", bus.csr_raddr, 32'd0);
        check_eq("reset:rd_data", bus.resp_rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //     name      f3      csr       rs1_data      idx    rd     csr_val       rd wr wdata         lat rdwe  rd_data       ill  hs
        run_op("csrrw",  3'b001, 12'h340, 32'hDEADBEEF, 5'd3,  5'd5,  32'h12345678, 1, 1, 32'hDEADBEEF, 3, 1'b1, 32'h12345678, 1'b0, 1'b1);
        run_op("csrrs0", 3'b010, 12'h300, 32'hFFFFFFFF, 5'd0,  5'd7,  32'h00001888, 1, 0, 32'h0,        2, 1'b1, 32'h00001888, 1'b0, 1'b1);
        run_op("csrrci", 3'b111, 12'h304, 32'h0,        5'h0A, 5'd0,  32'hFFFFFFFF, 1, 1, 32'hFFFFFFF5, 3, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
        run_op("ill100", 3'b100, 12'h340, 32'h1,        5'd1,  5'd4,  32'hAAAA5555, 0, 0, 32'h0,        1, 1'b0, 32'h0,        1'b1, 1'b1);
        run_op("ill000", 3'b000, 12'h341, 32'h1,        5'd2,  5'd0,  32'hAAAA5555, 0, 0, 32'h0,        1, 1'b0, 32'h0,        1'b1, 1'b1);
        run_op("rwi_x0", 3'b101, 12'h305, 32'hFFFFFFFF, 5'h1F, 5'd0,  32'h0BADF00D, 0, 1, 32'h0000001F, 2, 1'b0, 32'h0,        1'b0, 1'b1);
        run_op("rs_rd0", 3'b010, 12'h342, 32'h0,        5'd0,  5'd0,  32'h00000080, 1, 0, 32'h0,        2, 1'b0, 32'h00000080, 1'b0, 1'b1);
        run_op("csrrs",  3'b010, 12'h00F, 32'h000000F0, 5'd4,  5'd9,  32'h0000000F, 1, 1, 32'h000000FF, 3, 1'b1, 32'h0000000F, 1'b0, 1'b1);
        run_op("csrrsi", 3'b110, 12'h344, 32'hFFFFFFFF, 5'h11, 5'd12, 32'h00000100, 1, 1, 32'h00000111, 3, 1'b1, 32'h00000100, 1'b0, 1'b1);
        run_op("ro_rd",  3'b010, 12'hF14, 32'h0,        5'd0,  5'd1,  32'h00000007, 1, 0, 32'h0,        2, 1'b1, 32'h00000007, 1'b0, 1'b1);
`ifdef CSR_ACCESS_UNIT_RO_CHECK_EN
        run_op("ro_wr",  3'b001, 12'hF14, 32'h00000011, 5'd1,  5'd1,  32'h00000007, 0, 0, 32'h0,        1, 1'b0, 32'h0,        1'b1, 1'b1);
`else
        run_op("ro_wr",  3'b001, 12'hF14, 32'h00000011, 5'd1,  5'd1,  32'h00000007, 1, 1, 32'h00000011, 3, 1'b1, 32'h00000007, 1'b0, 1'b1);
`endif

        // Backpressure: hold the response, present a new request meanwhile
        bus.resp_ready = 1'b0;
        run_op("bp",     3'b010, 12'h343, 32'h0,        5'd0,  5'd6,  32'hCAFE0001, 1, 0, 32'h0,        2, 1'b1, 32'hCAFE0001, 1'b0, 1'b0);
        @(negedge clk);
        drive_req(3'b001, 12'h345, 32'h00000055, 5'd8, 5'd2);
        bus.csr_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp:ready_low", {31'd0, bus.req_ready}, 32'd0);
            check_eq("bp:valid_held", {31'd0, bus.resp_valid}, 32'd1);
            check_eq("bp:data_held", bus.resp_rd_data, 32'hCAFE0001);
            check_eq("bp:idx_held", {27'd0, bus.resp_rd_idx}, 32'd6);
            check_eq("bp:no_read", bus.csr_raddr, 32'd0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp:after_hs_ready", {31'd0, bus.req_ready}, 32'd1);
        check_eq("bp:after_hs_valid", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("bp:not_yet_read", bus.csr_raddr, 32'd0);
        run_op("bp_next", 3'b001, 12'h345, 32'h00000055, 5'd8, 5'd2, 32'h00000033, 1, 1, 32'h00000055, 3, 1'b1, 32'h00000033, 1'b0, 1'b1);

        // Reset pulsed while the write is on the bus
        @(negedge clk);
        drive_req(3'b001, 12'h340, 32'hA5A5A5A5, 5'd2, 5'd3);
        bus.csr_rdata = 32'h11111111;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst:we_before", {31'd0, bus.csr_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst:we_dropped", {31'd0, bus.csr_we}, 32'd0);
        check_eq("rst:ready", {31'd0, bus.req_ready}, 32'd1);
        check_eq("rst:resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("rst:wdata", bus.csr_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid || bus.csr_we) stray++;
        end
        check_eq("rst:no_response", stray, 32'd0);
        run_op("post_rst", 3'b011, 12'h346, 32'h0000000F, 5'd5, 5'd10, 32'h000000FF, 1, 1, 32'h000000F0, 3, 1'b1, 32'h000000FF, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
